// File: rtl/counter_param_pkg.sv
// Shared constants for the parametrised counter:
// mode encodings and saturate/wrap select.
package counter_param_pkg;

   localparam logic [1:0] COUNT_UP        = 2'b00;
   localparam logic [1:0] COUNT_DOWN      = 2'b01;
   localparam logic [1:0] COUNT_STEP_DOWN = 2'b10;
   localparam logic [1:0] CHARGE          = 2'b11;

   localparam logic SAT_WRAP  = 1'b0;
   localparam logic SAT_CLAMP = 1'b1;

endpackage

// File: rtl/counter_step.sv
// Next-state logic for counter_param: computes the
// following count, boundary pulse and load pulse.
module counter_step
   import counter_param_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 3
) (
   input  logic [WIDTH-1:0] Q,
   input  logic [1:0]       MODO,
   input  logic             SAT,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] q_next,
   output logic             rco_next,
   output logic             load_next
);

   logic [WIDTH:0] q_x;
   logic [WIDTH:0] lim_x;
   logic [WIDTH:0] lim_p1;
   logic [WIDTH:0] step_x;
   logic           is_load;
   logic           oor;
   logic           sat_on;

   assign q_x     = {1'b0, Q};
   assign lim_x   = {1'b0, LIMIT};
   assign lim_p1  = lim_x + 1'b1;
   assign step_x  = (WIDTH+1)'(STEP);
   assign is_load = (MODO == CHARGE);
   assign oor     = (q_x > lim_x);
   assign sat_on  = (SAT == SAT_CLAMP);

   // A lowered LIMIT pulls an out-of-range count back first
   always_comb begin
      q_next    = Q;
      rco_next  = 1'b0;
      load_next = 1'b0;
      unique case (1'b1)
         is_load: begin
            q_next    = (D > LIMIT) ? LIMIT : D;
            load_next = 1'b1;
         end
         (!is_load && oor): begin
            q_next = LIMIT;
         end
         (MODO == COUNT_UP && !oor): begin
            if (q_x == lim_x) begin
               if (!sat_on) begin
                  q_next   = '0;
                  rco_next = 1'b1;
               end
            end else begin
               q_next   = WIDTH'(q_x + 1'b1);
               rco_next = sat_on && (q_x + 1'b1 == lim_x);
            end
         end
         (MODO == COUNT_DOWN && !oor): begin
            if (q_x == '0) begin
               if (!sat_on) begin
                  q_next   = LIMIT;
                  rco_next = 1'b1;
               end
            end else begin
               q_next   = WIDTH'(q_x - 1'b1);
               rco_next = sat_on && (q_x == 1);
            end
         end
         (MODO == COUNT_STEP_DOWN && !oor): begin
            if (sat_on) begin
               if (q_x > step_x) begin
                  q_next = WIDTH'(q_x - step_x);
               end else if (q_x != '0) begin
                  q_next   = '0;
                  rco_next = 1'b1;
               end
            end else if (q_x >= step_x) begin
               q_next = WIDTH'(q_x - step_x);
            end else if (step_x > lim_p1) begin
               q_next   = LIMIT;
               rco_next = 1'b1;
            end else begin
               q_next   = WIDTH'(q_x + lim_p1 - step_x);
               rco_next = 1'b1;
            end
         end
         default: begin
            q_next = Q;
         end
      endcase
   end

endmodule

// File: rtl/counter_param.sv
// WIDTH-bit up/down/step/load counter with modulo
// limit and wrap/saturate select; registered outputs.
module counter_param
   import counter_param_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 3
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [1:0]       MODO,
   input  logic             SAT,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             LOAD
);

   logic [WIDTH-1:0] q_next;
   logic             rco_next;
   logic             load_next;

   counter_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .Q         (Q),
      .MODO      (MODO),
      .SAT       (SAT),
      .LIMIT     (LIMIT),
      .D         (D),
      .q_next    (q_next),
      .rco_next  (rco_next),
      .load_next (load_next)
   );

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         Q    <= '0;
         RCO  <= 1'b0;
         LOAD <= 1'b0;
      end else if (ENABLE) begin
         Q    <= q_next;
         RCO  <= rco_next;
         LOAD <= load_next;
      end else begin
         RCO  <= 1'b0;
         LOAD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: directed scenarios on an 8-bit
// and a 32-bit instance plus randomized reference checks.
module tb_counter_param;

   localparam int STEP8  = 3;
   localparam int STEP32 = 5;

   logic        clk;
   logic        RESET;

   logic        en8;
   logic [1:0]  modo8;
   logic        sat8;
   logic [7:0]  lim8;
   logic [7:0]  d8;
   logic [7:0]  q8;
   logic        rco8;
   logic        load8;

   logic        en32;
   logic [1:0]  modo32;
   logic        sat32;
   logic [31:0] lim32;
   logic [31:0] d32;
   logic [31:0] q32;
   logic        rco32;
   logic        load32;

   longint m_q8;
   bit     m_r8;
   bit     m_l8;
   longint m_q32;
   bit     m_r32;
   bit     m_l32;

   int vec;
   int errs;

   counter_param #(.WIDTH(8), .STEP(STEP8)) dut8 (
      .clk    (clk),
      .RESET  (RESET),
      .ENABLE (en8),
      .MODO   (modo8),
      .SAT    (sat8),
      .LIMIT  (lim8),
      .D      (d8),
      .Q      (q8),
      .RCO    (rco8),
      .LOAD   (load8)
   );

   counter_param #(.WIDTH(32), .STEP(STEP32)) dut32 (
      .clk    (clk),
      .RESET  (RESET),
      .ENABLE (en32),
      .MODO   (modo32),
      .SAT    (sat32),
      .LIMIT  (lim32),
      .D      (d32),
      .Q      (q32),
      .RCO    (rco32),
      .LOAD   (load32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain integer statement of the counting rules
   function automatic void ref_next(
      input  longint st,
      input  longint q,
      input  bit     en,
      input  int     m,
      input  bit     s,
      input  longint lim,
      input  longint d,
      output longint nq,
      output bit     nr,
      output bit     nl
   );
      nq = q;
      nr = 0;
      nl = 0;
      if (!en) return;
      if (m == 3) begin
         nq = (d < lim) ? d : lim;
         nl = 1;
         return;
      end
      if (q > lim) begin
         nq = lim;
         return;
      end
      if (m == 0) begin
         if (q == lim) begin
            if (!s) begin
               nq = 0;
               nr = 1;
            end
         end else begin
            nq = q + 1;
            nr = s && (q + 1 == lim);
         end
      end else if (m == 1) begin
         if (q == 0) begin
            if (!s) begin
               nq = lim;
               nr = 1;
            end
         end else begin
            nq = q - 1;
            nr = s && (q == 1);
         end
      end else if (s) begin
         if (q > st) nq = q - st;
         else if (q > 0) begin
            nq = 0;
            nr = 1;
         end
      end else begin
         if (q >= st) nq = q - st;
         else if (st > lim + 1) begin
            nq = lim;
            nr = 1;
         end else begin
            nq = q + lim + 1 - st;
            nr = 1;
         end
      end
   endfunction

   task automatic tick();
      longint nq;
      bit     nr;
      bit     nl;
      @(posedge clk);
      if (RESET) begin
         ref_next(STEP8, m_q8, en8, int'(modo8), sat8,
                  longint'(lim8), longint'(d8), nq, nr, nl);
         m_q8 = nq;
         m_r8 = nr;
         m_l8 = nl;
         ref_next(STEP32, m_q32, en32, int'(modo32), sat32,
                  longint'(lim32), longint'(d32), nq, nr, nl);
         m_q32 = nq;
         m_r32 = nr;
         m_l32 = nl;
      end
      #1;
   endtask

   task automatic model_reset();
      m_q8  = 0;
      m_r8  = 0;
      m_l8  = 0;
      m_q32 = 0;
      m_r32 = 0;
      m_l32 = 0;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      en8 = 1'b1;
      modo8 = 2'b00;
      sat8 = 1'b0;
      lim8 = 8'd9;
      d8 = 8'd0;
      en32 = 1'b0;
      modo32 = 2'b00;
      sat32 = 1'b0;
      lim32 = '1;
      d32 = '0;
      model_reset();
      tick();
      tick();
      vec++;
      if ({q8, rco8, load8} !== 10'd0) begin
         errs++;
         $display("FAIL reset8 got q=%0d r=%b l=%b want 0",
                  q8, rco8, load8);
      end
      vec++;
      if ({q32, rco32, load32} !== 34'd0) begin
         errs++;
         $display("FAIL reset32 got q=%0h r=%b l=%b want 0",
                  q32, rco32, load32);
      end
      RESET = 1'b1;
   endtask

   task automatic test_up_wrap();
      int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      en8 = 1'b1;
      modo8 = 2'b00;
      sat8 = 1'b0;
      lim8 = 8'd9;
      for (int i = 0; i < 12; i++) begin
         tick();
         vec++;
         if (q8 !== 8'(exp_q[i]) || rco8 !== (i == 9)
             || load8 !== 1'b0) begin
            errs++;
            $display("FAIL up_wrap[%0d] got q=%0d r=%b want q=%0d r=%b",
                     i, q8, rco8, exp_q[i], (i == 9));
         end
      end
   endtask

   task automatic test_step_down(input bit s);
      int exp_q [4];
      bit exp_r [4];
      if (s) begin
         exp_q = '{4, 1, 0, 0};
         exp_r = '{0, 0, 1, 0};
      end else begin
         exp_q = '{4, 1, 254, 251};
         exp_r = '{0, 0, 1, 0};
      end
      lim8 = 8'd255;
      sat8 = s;
      modo8 = 2'b11;
      d8 = 8'd4;
      for (int i = 0; i < 4; i++) begin
         tick();
         modo8 = 2'b10;
         vec++;
         if (q8 !== 8'(exp_q[i]) || rco8 !== exp_r[i]
             || load8 !== (i == 0)) begin
            errs++;
            $display("FAIL step_sat%0d[%0d] got q=%0d r=%b l=%b want q=%0d r=%b",
                     s, i, q8, rco8, load8, exp_q[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_load_hold();
      lim8 = 8'd150;
      modo8 = 2'b11;
      d8 = 8'd200;
      tick();
      vec++;
      if (q8 !== 8'd150 || load8 !== 1'b1 || rco8 !== 1'b0) begin
         errs++;
         $display("FAIL load_clamp got q=%0d l=%b r=%b want 150 1 0",
                  q8, load8, rco8);
      end
      en8 = 1'b0;
      modo8 = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec++;
         if (q8 !== 8'd150 || load8 !== 1'b0 || rco8 !== 1'b0) begin
            errs++;
            $display("FAIL hold[%0d] got q=%0d l=%b r=%b want 150 0 0",
                     i, q8, load8, rco8);
         end
      end
      en8 = 1'b1;
   endtask

   task automatic test_limit_lower();
      lim8 = 8'd255;
      sat8 = 1'b0;
      modo8 = 2'b11;
      d8 = 8'd100;
      tick();
      lim8 = 8'd50;
      modo8 = 2'b00;
      tick();
      vec++;
      if (q8 !== 8'd50 || rco8 !== 1'b0) begin
         errs++;
         $display("FAIL oor_pull got q=%0d r=%b want 50 0", q8, rco8);
      end
      tick();
      vec++;
      if (q8 !== 8'd0 || rco8 !== 1'b1) begin
         errs++;
         $display("FAIL oor_wrap got q=%0d r=%b want 0 1", q8, rco8);
      end
   endtask

   task automatic test_wide_and_async();
      en8 = 1'b0;
      en32 = 1'b1;
      lim32 = 32'hFFFF_FFFF;
      sat32 = 1'b0;
      modo32 = 2'b11;
      d32 = 32'hFFFF_FFFF;
      tick();
      modo32 = 2'b00;
      tick();
      vec++;
      if (q32 !== 32'd0 || rco32 !== 1'b1) begin
         errs++;
         $display("FAIL wide_wrap got q=%0h r=%b want 0 1", q32, rco32);
      end
      modo32 = 2'b11;
      tick();
      #2;
      RESET = 1'b0;
      model_reset();
      #1;
      vec++;
      if (q32 !== 32'd0 || rco32 !== 1'b0 || load32 !== 1'b0) begin
         errs++;
         $display("FAIL async_rst got q=%0h r=%b l=%b want 0 0 0",
                  q32, rco32, load32);
      end
      #2;
      RESET = 1'b1;
      en32 = 1'b0;
      en8 = 1'b1;
   endtask

   task automatic test_random();
      int pick;
      for (int i = 0; i < 400; i++) begin
         en8 = ($urandom_range(0, 9) != 0);
         en32 = ($urandom_range(0, 9) != 0);
         modo8 = 2'($urandom_range(0, 3));
         modo32 = 2'($urandom_range(0, 3));
         sat8 = 1'($urandom_range(0, 1));
         sat32 = 1'($urandom_range(0, 1));
         d8 = 8'($urandom);
         d32 = $urandom;
         if (i % 16 == 0) begin
            pick = $urandom_range(0, 4);
            case (pick)
               0: begin lim8 = 8'd0; lim32 = 32'd0; end
               1: begin lim8 = 8'd1; lim32 = 32'd2; end
               2: begin lim8 = 8'($urandom_range(2, 12));
                        lim32 = $urandom_range(3, 20); end
               3: begin lim8 = 8'($urandom); lim32 = $urandom; end
               default: begin lim8 = '1; lim32 = '1; end
            endcase
         end
         tick();
         vec++;
         if (q8 !== 8'(m_q8) || rco8 !== m_r8 || load8 !== m_l8
             || (rco8 && load8)) begin
            errs++;
            $display("FAIL rand8[%0d] got q=%0d r=%b l=%b want q=%0d r=%b l=%b",
                     i, q8, rco8, load8, m_q8, m_r8, m_l8);
         end
         vec++;
         if (q32 !== 32'(m_q32) || rco32 !== m_r32
             || load32 !== m_l32 || (rco32 && load32)) begin
            errs++;
            $display("FAIL rand32[%0d] got q=%0h r=%b l=%b want q=%0h r=%b l=%b",
                     i, q32, rco32, load32, m_q32, m_r32, m_l32);
         end
      end
   endtask

   initial begin
      vec = 0;
      errs = 0;
      test_reset();
      test_up_wrap();
      test_step_down(1'b0);
      test_step_down(1'b1);
      test_load_hold();
      test_limit_lower();
      test_wide_and_async();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
